sp_mem_rw_arb: RTL and testbench

Request front-end that sits directly upstream of the single-port synchronous RAM and drives its write-enable, address and write-data pins. It also consumes the RAM's registered read data. The block merges an independent write channel and read channel onto the one RAM port, and turns the RAM's fixed 1-cycle read latency into a valid/ready response stream. A 3-entry response buffer lets reads issue at full rate without a combinational path from `rsp_ready` to `rd_ready`.

---
 rtl/sp_mem_rw_arb_if.sv | 35 +++
 rtl/sp_mem_rw_arb.sv | 91 +++++++++
 tb/tb_sp_mem_rw_arb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sp_mem_rw_arb_if.sv
// Request/response bundle between the requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface sp_mem_rw_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr, rsp_ready, mem_dout,
    output wr_ready, rd_ready, rsp_valid, rsp_data,
    output mem_we, mem_addr, mem_din
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr, rsp_ready, mem_dout,
    input  wr_ready, rd_ready, rsp_valid, rsp_data,
    input  mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sp_mem_rw_arb.sv
// Write/read merge onto a single-port RAM with a 3-entry response buffer.
// SP_MEM_ARB_WR_PRIO_EN: fixed write priority instead of round-robin.
module sp_mem_rw_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  sp_mem_rw_arb_if.slave bus
);

  logic [1:0] occ_q, occ_d;
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic       inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_q [3];

  logic [2:0] credit;
  logic       rd_elig, wr_elig;
  logic       wr_gnt, rd_gnt;
  logic       push, pop;

  // Buffer slots already owned plus the one read whose data is on mem_dout
  assign credit  = {1'b0, occ_q} + {2'b00, inflight_q};
  assign rd_elig = bus.rd_valid && (credit < 3'd3);
  assign wr_elig = bus.wr_valid;

`ifdef SP_MEM_ARB_WR_PRIO_EN
  always_comb begin
    wr_gnt = rst_n && wr_elig;
    rd_gnt = rst_n && rd_elig && !wr_elig;
  end
`else
  logic rr_rd_q, rr_rd_d;

  always_comb begin
    wr_gnt  = rst_n && wr_elig && (!rd_elig || !rr_rd_q);
    rd_gnt  = rst_n && rd_elig && (!wr_elig || rr_rd_q);
    rr_rd_d = rr_rd_q;
    if (wr_elig && rd_elig) rr_rd_d = ~rr_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_rd_q <= 1'b0;
    else        rr_rd_q <= rr_rd_d;
  end
`endif

  assign bus.wr_ready = wr_gnt;
  assign bus.rd_ready = rd_gnt;
  assign bus.mem_we   = wr_gnt;
  assign bus.mem_addr = wr_gnt ? bus.wr_addr : bus.rd_addr;
  assign bus.mem_din  = bus.wr_data;

  assign push = inflight_q;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    inflight_d = rd_gnt;
    occ_d      = occ_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (push && !pop) occ_d = occ_q + 2'd1;
    if (pop && !push) occ_d = occ_q - 2'd1;
    if (push) wptr_d = (wptr_q == 2'd2) ? 2'd0 : wptr_q + 2'd1;
    if (pop)  rptr_d = (rptr_q == 2'd2) ? 2'd0 : rptr_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Payload needs no reset; occupancy alone qualifies it
  always_ff @(posedge clk) begin
    if (push) buf_q[wptr_q] <= bus.mem_dout;
  end

  assign bus.rsp_valid = (occ_q != 2'd0);
  assign bus.rsp_data  = buf_q[rptr_q];

endmodule

// File: tb/tb_sp_mem_rw_arb.sv
// Directed bench for sp_mem_rw_arb with a behavioural single-port RAM.
// Exercises reset, latency, arbitration, backpressure, streaming, mid-run reset.
module tb_sp_mem_rw_arb;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  sp_mem_rw_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sp_mem_rw_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] ram_dout;
  always_ff @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    ram_dout <= ram[bus.mem_addr];
  end
  assign bus.mem_dout = ram_dout;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Buffer must never be pushed while full
  always @(posedge clk) begin
    if (rst_n && dut.inflight_q && dut.occ_q == 2'd3 && !(bus.rsp_valid && bus.rsp_ready)) begin
      tests++;
      fails++;
      $error("FAIL overflow: observed push into full buffer expected none");
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
  endtask

  logic exp_w;

  initial begin
    bus.wr_valid  = 1'b1;
    bus.rd_valid  = 1'b1;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_addr   = '0;
    bus.rsp_ready = 1'b1;

    // Reset with both channels requesting
    repeat (2) cyc();
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_rd_ready", bus.rd_ready, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Write then read back: 2-cycle latency
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 8'h05;
    bus.wr_data  = 32'hDEADBEEF;
    #1;
    chk("wr_ready", bus.wr_ready, 1'b1);
    chk("wr_mem_we", bus.mem_we, 1'b1);
    chk("wr_mem_addr", bus.mem_addr, 8'h05);
    cyc();
    idle();
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 8'h05;
    #1;
    chk("rd_ready", bus.rd_ready, 1'b1);
    chk("rd_mem_we", bus.mem_we, 1'b0);
    cyc();
    idle();
    #1;
    chk("lat_n1_valid", bus.rsp_valid, 1'b0);
    cyc();
    chk("lat_n2_valid", bus.rsp_valid, 1'b1);
    chk("lat_n2_data", bus.rsp_data, 32'hDEADBEEF);
    cyc();
    chk("lat_popped", bus.rsp_valid, 1'b0);

    // Contested arbitration over 6 cycles
    for (int i = 0; i < 6; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 8'h40 + 8'(i);
      bus.wr_data  = 32'h4000_0000 + i;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 8'h30 + 8'(i);
      #1;
`ifdef SP_MEM_ARB_WR_PRIO_EN
      exp_w = 1'b1;
`else
      exp_w = (i % 2 == 0);
`endif
      chk($sformatf("arb_w%0d", i), bus.wr_ready, exp_w);
      chk($sformatf("arb_r%0d", i), bus.rd_ready, !exp_w);
      cyc();
    end
    idle();
    repeat (3) cyc();
    chk("arb_drained", bus.rsp_valid, 1'b0);

    // Preload via the write channel
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 8'h10 + 8'(i);
      bus.wr_data  = 32'h1000_0000 + i;
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 8'h20 + 8'(i);
      bus.wr_data  = 32'hA500_0000 + i;
      cyc();
    end
    idle();
    cyc();

    // Backpressure: three reads fit, the fourth waits
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 8'h10 + 8'(i);
      #1;
      chk($sformatf("bp_rd_ready%0d", i), bus.rd_ready, (i < 3));
      cyc();
    end
    chk("bp_full_block", bus.rd_ready, 1'b0);
    chk("bp_head", bus.rsp_data, 32'h1000_0000);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_reenable", bus.rd_ready, 1'b1);
    cyc();
    idle();
    bus.rsp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk($sformatf("bp_valid%0d", i), bus.rsp_valid, 1'b1);
      chk($sformatf("bp_data%0d", i), bus.rsp_data, 32'h1000_0000 + i);
      cyc();
    end
    chk("bp_empty", bus.rsp_valid, 1'b0);

    // Streaming: 16 back-to-back reads
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 8'h20 + 8'(c);
      end else begin
        bus.rd_valid = 1'b0;
      end
      #1;
      if (c < 16) chk($sformatf("st_rd_ready%0d", c), bus.rd_ready, 1'b1);
      chk($sformatf("st_valid%0d", c), bus.rsp_valid, (c >= 2));
      if (c >= 2) chk($sformatf("st_data%0d", c - 2), bus.rsp_data, 32'hA500_0000 + (c - 2));
      cyc();
    end
    chk("st_done", bus.rsp_valid, 1'b0);

    // Reset with 2 buffered responses and 1 in flight
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 8'h20 + 8'(i);
      cyc();
    end
    idle();
    chk("mr_pre_valid", bus.rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid_drop", bus.rsp_valid, 1'b0);
    chk("mr_rd_ready", bus.rd_ready, 1'b0);
    cyc();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("mr_quiet%0d", i), bus.rsp_valid, 1'b0);
    end
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 8'h05;
    #1;
    chk("mr_new_rd_ready", bus.rd_ready, 1'b1);
    cyc();
    idle();
    cyc();
    chk("mr_new_valid", bus.rsp_valid, 1'b1);
    chk("mr_new_data", bus.rsp_data, 32'hDEADBEEF);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
